instr_issue_seq: RTL and testbench

INSTR_ISSUE_SEQ -- requirements
Module: instr_issue_seq

---
 rtl/instr_seq_pkg.sv | 18 +
 rtl/instr_issue_seq_prog_ram.sv | 28 ++
 rtl/instr_issue_seq.sv | 173 +++++++++++++++++
 tb/tb_instr_issue_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// ============================================================
// Package : instr_seq_pkg
// Purpose : FSM state encoding and default sizing for instr_issue_seq.
// Rev     : 1.0
// ============================================================
`default_nettype none
package instr_seq_pkg;
  localparam int c_def_dw      = 32;
  localparam int c_def_depth   = 32;
  localparam int c_def_max_out = 4;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_issue     = 3'd1;
  localparam logic [2:0] c_st_wait_step = 3'd2;
  localparam logic [2:0] c_st_drain     = 3'd3;
  localparam logic [2:0] c_st_done      = 3'd4;
endpackage
`default_nettype wire

// File: rtl/instr_issue_seq_prog_ram.sv
// ============================================================
// Module  : prog_ram
// Purpose : program store, one synchronous write port and one
//           combinational read port; contents are never reset.
// Rev     : 1.0
// ============================================================
`default_nettype none
module prog_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/instr_issue_seq.sv
// ============================================================
// Module  : instr_issue_seq
// Purpose : issues a stored program as a flow-controlled request stream
//           bounded by an outstanding-request window, with single-step.
// Rev     : 1.0
// ============================================================
`default_nettype none
module instr_issue_seq
  import instr_seq_pkg::*;
#(
  parameter int DW      = c_def_dw,
  parameter int DEPTH   = c_def_depth,
  parameter int MAX_OUT = c_def_max_out,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1,
  localparam int OW     = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          mode,
  input  logic          step,
  input  logic          abort,
  output logic          req_vaild,
  input  logic          req_ready,
  output logic [DW-1:0] req_data,
  input  logic          rsp_vaild,
  output logic          rsp_ready,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  output logic [OW-1:0] outstanding,
  output logic [AW:0]   issued_cnt,
  output logic [AW:0]   retired_cnt
);
  logic [2:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] issued_q, issued_d;
  logic [LW-1:0] retired_q, retired_d;
  logic [OW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          abort_pend_q, abort_pend_d;

  logic          w_hs_req;
  logic          w_hs_rsp;
  logic          w_len_ok;
  logic          w_start_ok;
  logic [DW-1:0] w_rd_data;

  assign w_hs_req   = valid_q & req_ready;
  assign w_hs_rsp   = rsp_vaild & (out_q != '0);
  assign w_len_ok   = (prog_len != '0) && (prog_len <= LW'(DEPTH));
  assign w_start_ok = (state_q == c_st_idle) && start && w_len_ok;

  // Read address follows the next issue index so the word is ready to register.
  prog_ram #(.DW(DW), .DEPTH(DEPTH)) u_prog_ram (
    .clk     (clk),
    .i_we    (load_en & (state_q == c_st_idle)),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (issued_d[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    issued_d  = issued_q + LW'(w_hs_req);
    retired_d = retired_q + LW'(w_hs_rsp);
    out_d     = out_q + OW'(w_hs_req) - OW'(w_hs_rsp);
    if (w_start_ok) begin
      issued_d  = '0;
      retired_d = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    valid_d      = valid_q;
    data_d       = data_q;
    err_d        = 1'b0;
    abort_pend_d = abort_pend_q;
    case (state_q)
      c_st_idle: begin
        abort_pend_d = 1'b0;
        if (start) begin
          if (w_len_ok) begin
            state_d = c_st_issue;
            mode_d  = mode;
            len_d   = prog_len;
            valid_d = 1'b1;
            data_d  = w_rd_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      c_st_issue: begin
        if (w_hs_req || !valid_q) begin
          valid_d = 1'b0;
          if (abort || abort_pend_q)         state_d = c_st_drain;
          else if (issued_d == len_q)        state_d = c_st_drain;
          else if (mode_q && w_hs_req)       state_d = c_st_wait_step;
          else if (out_d < OW'(MAX_OUT)) begin
            valid_d = 1'b1;
            data_d  = w_rd_data;
          end
        end else if (abort) begin
          // A word already presented must still complete its handshake.
          abort_pend_d = 1'b1;
        end
      end
      c_st_wait_step: begin
        if (abort) begin
          state_d = c_st_drain;
        end else if (step && (out_q == '0)) begin
          state_d = c_st_issue;
          valid_d = 1'b1;
          data_d  = w_rd_data;
        end
      end
      c_st_drain: begin
        if (out_q == '0) state_d = c_st_done;
      end
      c_st_done: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= c_st_idle;
      mode_q       <= 1'b0;
      len_q        <= '0;
      issued_q     <= '0;
      retired_q    <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      retired_q    <= retired_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign req_vaild   = valid_q;
  assign req_data    = data_q;
  assign rsp_ready   = (out_q != '0);
  assign busy        = (state_q != c_st_idle);
  assign done        = (state_q == c_st_done);
  assign err_len     = err_q;
  assign outstanding = out_q;
  assign issued_cnt  = issued_q;
  assign retired_cnt = retired_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_issue_seq.sv
// ============================================================
// Module  : tb_instr_issue_seq
// Purpose : self-checking bench for instr_issue_seq against a
//           count-based reference model of the request/response flow.
// Rev     : 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none
module tb_instr_issue_seq;
  localparam int DW = 32, DEPTH = 32, MAX_OUT = 4, AW = 5, OW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en, start, mode, step, abort, req_ready, rsp_vaild;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [AW:0]   prog_len;
  logic          req_vaild, rsp_ready, busy, done, err_len;
  logic [DW-1:0] req_data;
  logic [OW-1:0] outstanding;
  logic [AW:0]   issued_cnt, retired_cnt;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] prog [DEPTH];

  always #5 clk = ~clk;

  instr_issue_seq #(.DW(DW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .mode(mode), .step(step), .abort(abort),
    .req_vaild(req_vaild), .req_ready(req_ready), .req_data(req_data),
    .rsp_vaild(rsp_vaild), .rsp_ready(rsp_ready), .busy(busy), .done(done), .err_len(err_len),
    .outstanding(outstanding), .issued_cnt(issued_cnt), .retired_cnt(retired_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d; prog[a] = d;
    tick;
    load_en = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_vaild"}, 64'(req_vaild), 64'(0));
    chk({tag, "_data"}, 64'(req_data), 64'(0));
    chk({tag, "_rsp_ready"}, 64'(rsp_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err_len), 64'(0));
    chk({tag, "_out"}, 64'(outstanding), 64'(0));
    chk({tag, "_issued"}, 64'(issued_cnt), 64'(0));
    chk({tag, "_retired"}, 64'(retired_cnt), 64'(0));
  endtask

  // Model: words leave in program order; the window and step/abort rules
  // decide whether a word may be offered; done follows completion by one cycle.
  task automatic run(input int len, input bit md, input int rdy_pct, input int rsp_pct,
                     input int rdy0_from, input int rdy0_len, input int rsp_hold,
                     input int abort_cyc);
    int iss = 0, outs = 0, ret = 0;
    bit aborted = 0, pend = 0, permit = 1, fin_prev = 0, fin, ev, hsq, hsr, got_done = 0;
    prog_len = (AW+1)'(len); mode = md; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      req_ready = (c >= rdy0_from && c < rdy0_from + rdy0_len) ? 1'b0
                  : (int'($urandom_range(99)) < rdy_pct);
      rsp_vaild = (c < rsp_hold) ? 1'b0 : (int'($urandom_range(99)) < rsp_pct);
      step      = (int'($urandom_range(99)) < 30);
      abort     = (c == abort_cyc);
      @(negedge clk);
      ev  = aborted ? pend : (iss < len && outs < MAX_OUT && (!md || permit));
      fin = (outs == 0) && (iss == len || (aborted && !pend));
      chk("req_vaild", 64'(req_vaild), 64'(ev));
      if (ev) chk("req_data", 64'(req_data), 64'(prog[iss]));
      chk("outstanding", 64'(outstanding), 64'(outs));
      chk("issued_cnt", 64'(issued_cnt), 64'(iss));
      chk("retired_cnt", 64'(retired_cnt), 64'(ret));
      chk("rsp_ready", 64'(rsp_ready), 64'(outs > 0));
      chk("busy_run", 64'(busy), 64'(1));
      chk("done", 64'(done), 64'(fin_prev));
      got_done = fin_prev;
      hsq = ev && req_ready;
      hsr = rsp_vaild && (outs > 0);
      if (abort && !aborted) begin
        aborted = 1'b1;
        pend    = ev && !hsq;
      end else if (hsq) begin
        pend = 1'b0;
      end
      if (md) begin
        if (hsq) permit = 1'b0;
        else if (step && outs == 0) permit = 1'b1;
      end
      iss += int'(hsq);
      outs += int'(hsq) - int'(hsr);
      ret += int'(hsr);
      fin_prev = fin;
      tick;
    end
    chk("finished", 64'(got_done), 64'(1));
    req_ready = 1'b0; rsp_vaild = 1'b0; step = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
    tick;
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
    start = 1'b0; mode = 1'b0; step = 1'b0; abort = 1'b0; req_ready = 1'b0; rsp_vaild = 1'b0;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    tick;
    reset = 1'b1;
    tick;

    for (int a = 0; a < DEPTH; a++) load_word(a, $urandom);
    load_word(0, 32'h0054A90B);
    load_word(1, 32'h403FFFF6);
    load_word(2, 32'h4200000B);

    // basic program, response one cycle after each request
    run(3, 1'b0, 100, 100, -1, 0, 0, -1);
    @(negedge clk);
    chk("basic_retired", 64'(retired_cnt), 64'(3));
    tick;

    // window fills with responses held off, then drains
    run(8, 1'b0, 100, 100, -1, 0, 12, -1);

    // single-step runs
    for (int i = 0; i < 3; i++) run(2, 1'b1, 100, 50, -1, 0, 0, -1);

    // ready held low for the first five cycles
    run(6, 1'b0, 100, 100, 0, 5, 0, -1);

    // abort while word 2 is held valid
    run(6, 1'b0, 100, 100, 1, 3, 0, 2);
    @(negedge clk);
    chk("abort_issued", 64'(issued_cnt), 64'(2));
    chk("abort_retired", 64'(retired_cnt), 64'(2));
    tick;

    // illegal lengths
    for (int k = 0; k < 2; k++) begin
      prog_len = (k == 0) ? 6'd0 : 6'(DEPTH + 1);
      start = 1'b1;
      tick;
      start = 1'b0;
      @(negedge clk);
      chk("err_len_pulse", 64'(err_len), 64'(1));
      chk("err_busy", 64'(busy), 64'(0));
      tick;
      @(negedge clk);
      chk("err_len_clear", 64'(err_len), 64'(0));
      tick;
    end

    // reset mid-run with two requests outstanding; a busy-time write must not land
    prog_len = 6'd3; mode = 1'b0; req_ready = 1'b1; rsp_vaild = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    load_en = 1'b1; load_addr = '0; load_data = 32'hDEADBEEF;
    tick;
    load_en = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_out", 64'(outstanding), 64'(2));
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2 reset = 1'b0;
    #1 check_quiet("async_reset");
    tick;
    reset = 1'b1;
    tick;
    run(3, 1'b0, 100, 100, -1, 0, 0, -1);

    // randomized runs
    for (int i = 0; i < 12; i++) begin
      for (int w = 0; w < 4; w++) load_word(int'($urandom_range(DEPTH - 1)), $urandom);
      run(int'($urandom_range(1, DEPTH)), 1'($urandom_range(1)),
          int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
          -1, 0, int'($urandom_range(0, 6)),
          ($urandom_range(2) == 0) ? int'($urandom_range(0, 20)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
